// File: rtl/parcv1_pkg.sv
// parcv1_pkg: shared types for the parcv1 memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e     : which core port owns the outstanding memory transaction
package parcv1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/parcv1_arb_prio.sv
// parcv1_arb_prio: combinational priority pick between fetch and data
// requests, plus the consecutive-data-grant counter that guarantees
// fetch progress.
//   clk, rst    : clock, synchronous active-high reset
//   imem_req_i  : fetch request pending
//   dmem_req_i  : data request pending
//   decide_i    : an arbitration decision is taken this cycle
//   winner_o    : selected owner (valid whenever a request is pending)
module parcv1_arb_prio
  import parcv1_pkg::*;
#(
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   imem_req_i,
  input  logic   dmem_req_i,
  input  logic   decide_i,
  output owner_e winner_o
);

  localparam int unsigned RW = $clog2(MAX_D_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_D_RUN);

  logic [RW-1:0] d_run_q, d_run_d;
  logic          d_win;

  always_comb begin
    // Data wins unless the fetch side has already waited through a full run.
    d_win    = dmem_req_i && !(imem_req_i && (d_run_q == RUN_MAX));
    winner_o = d_win ? OWN_D : OWN_I;

    d_run_d = d_run_q;
    if (decide_i) begin
      if (d_win && imem_req_i) begin
        d_run_d = (d_run_q == RUN_MAX) ? d_run_q : d_run_q + 1'b1;
      end else begin
        d_run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_run_q <= '0;
    end else begin
      d_run_q <= d_run_d;
    end
  end

endmodule

// File: rtl/parcv1_mem_arbiter.sv
// parcv1_mem_arbiter: serialises the parcv1 core's fetch (imem) and data
// (dmem) request ports onto one request/grant/response memory channel with
// a single outstanding transaction, routing each response to its owner.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req/imem_addr                : fetch request (held until imem_resp)
//   imem_data/imem_resp               : fetch data and completion pulse
//   dmem_req/addr/wdata/we            : data request (held until dmem_resp)
//   dmem_data/dmem_resp               : load data and completion pulse
//   mem_req/addr/wdata/we, mem_gnt    : registered request to memory
//   mem_resp/mem_rdata                : memory completion and read data
//   err_stray                         : sticky, response with nothing pending
module parcv1_mem_arbiter
  import parcv1_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_data,
  output logic            imem_resp,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  output logic [XLEN-1:0] dmem_data,
  output logic            dmem_resp,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic            mem_gnt,
  input  logic            mem_resp,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err_stray
);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            decide;
  logic            resp_ok;
  owner_e          winner;

  parcv1_arb_prio #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .imem_req_i (imem_req),
    .dmem_req_i (dmem_req),
    .decide_i   (decide),
    .winner_o   (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    decide  = 1'b0;

    case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          decide  = 1'b1;
          state_d = ISSUE;
          owner_d = winner;
          if (winner == OWN_D) begin
            addr_d  = dmem_addr;
            wdata_d = dmem_wdata;
            we_d    = dmem_we;
          end else begin
            addr_d  = imem_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only a response in WAIT belongs to the outstanding transaction; any
  // other response (including one coinciding with the grant) is stray.
  always_comb begin
    resp_ok   = (state_q == WAIT) && mem_resp;
    imem_resp = resp_ok && (owner_q == OWN_I);
    dmem_resp = resp_ok && (owner_q == OWN_D);
    err_d     = err_q || (mem_resp && (state_q != WAIT));
    imem_data = mem_rdata;
    dmem_data = mem_rdata;
    mem_req   = (state_q == ISSUE);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = we_q;
    err_stray = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

endmodule
